// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one i2c master engine among NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to abort transactions that stay BUSY for TIMEOUT_CYCLES.
module i2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                 clock_100Khz,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_wr_en,
  input  logic [7*NUM_REQ-1:0] i_addr_ic,
  input  logic [8*NUM_REQ-1:0] i_addr_reg,
  input  logic [8*NUM_REQ-1:0] i_data_wr,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [NUM_REQ-1:0]   o_done,
  output logic [NUM_REQ-1:0]   o_err,
  output logic [7:0]           o_data_read,
  output logic [6:0]           o_addr_ic,
  output logic [7:0]           o_addr_reg,
  output logic [7:0]           o_data_wr,
  output logic                 o_wr_en,
  output logic                 o_en_I2C,
  input  logic                 i_flag_w,
  input  logic                 i_flag_r,
  input  logic [7:0]           i_data_read
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("i2c_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   ptr_after;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W:0]     cand_sum;
  logic               pick_valid;
  logic               done_flag;
  logic               tmo_expired;
  logic               do_latch, do_finish, do_abort;
  logic [NUM_REQ-1:0] owner_onehot;

  logic [6:0] req_addr_ic  [NUM_REQ];
  logic [7:0] req_addr_reg [NUM_REQ];
  logic [7:0] req_data_wr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_addr_ic[g]  = i_addr_ic[7*g +: 7];
    assign req_addr_reg[g] = i_addr_reg[8*g +: 8];
    assign req_data_wr[g]  = i_data_wr[8*g +: 8];
  end

  // First pending requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand_sum >= (PTR_W+1)'(NUM_REQ)) cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
      cand = cand_sum[PTR_W-1:0];
      if (!pick_valid && i_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Only the flag matching the latched operation ends a transaction.
  assign done_flag    = o_wr_en ? i_flag_w : i_flag_r;
  assign owner_onehot = NUM_REQ'(1) << owner;
  assign ptr_after    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    state_next = state;
    do_latch   = 1'b0;
    do_finish  = 1'b0;
    do_abort   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          do_latch   = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done_flag) begin
          do_finish  = 1'b1;
          state_next = ST_RELEASE;
        end else if (tmo_expired) begin
          do_abort   = 1'b1;
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!i_flag_w && !i_flag_r) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_100Khz or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      owner       <= '0;
      o_grant     <= '0;
      o_done      <= '0;
      o_data_read <= '0;
      o_addr_ic   <= '0;
      o_addr_reg  <= '0;
      o_data_wr   <= '0;
      o_wr_en     <= 1'b0;
      o_en_I2C    <= 1'b0;
    end else begin
      state  <= state_next;
      o_done <= '0;
      if (do_latch) begin
        owner      <= pick_idx;
        o_grant    <= NUM_REQ'(1) << pick_idx;
        o_wr_en    <= i_wr_en[pick_idx];
        o_addr_ic  <= req_addr_ic[pick_idx];
        o_addr_reg <= req_addr_reg[pick_idx];
        o_data_wr  <= req_data_wr[pick_idx];
        o_en_I2C   <= 1'b1;
      end
      if (do_finish || do_abort) begin
        o_en_I2C <= 1'b0;
        o_grant  <= '0;
        o_done   <= owner_onehot;
        ptr      <= ptr_after;
        if (do_abort)      o_data_read <= 8'h00;
        else if (!o_wr_en) o_data_read <= i_data_read;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_expired = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock_100Khz or posedge i_reset) begin
    if (i_reset) begin
      tmo_cnt <= '0;
      o_err   <= '0;
    end else begin
      o_err <= '0;
      if (do_latch)                            tmo_cnt <= '0;
      else if (state == ST_BUSY && !tmo_expired) tmo_cnt <= tmo_cnt + 1'b1;
      if (do_abort) o_err <= owner_onehot;
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign o_err       = '0;
`endif

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level round-robin reference model.
module tb_i2c_arbiter;
  localparam int N   = 4;
  localparam int TMO = 20;

  logic           clock_100Khz = 1'b0;
  logic           i_reset;
  logic [N-1:0]   i_req, i_wr_en;
  logic [7*N-1:0] i_addr_ic;
  logic [8*N-1:0] i_addr_reg, i_data_wr;
  logic [N-1:0]   o_grant, o_done, o_err;
  logic [7:0]     o_data_read, o_addr_reg, o_data_wr;
  logic [6:0]     o_addr_ic;
  logic           o_wr_en, o_en_I2C;
  logic           i_flag_w, i_flag_r;
  logic [7:0]     i_data_read;

  i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_100Khz(clock_100Khz), .i_reset(i_reset),
    .i_req(i_req), .i_wr_en(i_wr_en), .i_addr_ic(i_addr_ic),
    .i_addr_reg(i_addr_reg), .i_data_wr(i_data_wr),
    .o_grant(o_grant), .o_done(o_done), .o_err(o_err),
    .o_data_read(o_data_read), .o_addr_ic(o_addr_ic), .o_addr_reg(o_addr_reg),
    .o_data_wr(o_data_wr), .o_wr_en(o_wr_en), .o_en_I2C(o_en_I2C),
    .i_flag_w(i_flag_w), .i_flag_r(i_flag_r), .i_data_read(i_data_read)
  );

  always #5 clock_100Khz = ~clock_100Khz;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_fields(input int k, input logic [6:0] ic, input logic [7:0] rg,
                            input logic [7:0] dw, input logic wr);
    i_addr_ic[7*k +: 7]  = ic;
    i_addr_reg[8*k +: 8] = rg;
    i_data_wr[8*k +: 8]  = dw;
    i_wr_en[k]           = wr;
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    i_req    = '0;
    i_flag_w = 1'b0;
    i_flag_r = 1'b0;
    repeat (2) @(negedge clock_100Khz);
    i_reset = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input int k);
    int n;
    n = 0;
    while (o_grant == '0 && n < 20) begin
      @(negedge clock_100Khz);
      n++;
    end
    check({tag, " grant"}, o_grant, N'(1) << k);
  endtask

  // Master stand-in: raise the matching flag, expect done next cycle, then clear flags.
  task automatic serve(input int k, input string tag);
    wait_grant(tag, k);
    if (o_wr_en) i_flag_w = 1'b1;
    else         i_flag_r = 1'b1;
    @(negedge clock_100Khz);
    check({tag, " done"}, o_done, N'(1) << k);
    check({tag, " en low"}, o_en_I2C, 1'b0);
    i_flag_w = 1'b0;
    i_flag_r = 1'b0;
    @(negedge clock_100Khz);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         fw, fr;
    logic [7:0]   rd;
    logic [N-1:0] grant, done;
    logic         en;
    logic [7:0]   dout;
    logic         chk_cmd;
    logic [6:0]   ic;
    logic [7:0]   rg, dw;
    logic         wr;
  } vec_t;

  vec_t vt [10];

  // Reference-model state for the randomized run.
  int         ptr_m, owner_m, exp_k, m_phase, m_cnt, grants_seen, bad;
  logic       exp_done;
  logic       lat_wr;
  logic [6:0] lat_ic;
  logic [7:0] lat_rg, lat_dw, m_data, dout_m;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset     = 1'b1;
    i_req       = '0;
    i_wr_en     = '0;
    i_addr_ic   = '0;
    i_addr_reg  = '0;
    i_data_wr   = '0;
    i_flag_w    = 1'b0;
    i_flag_r    = 1'b0;
    i_data_read = 8'h00;

    // Reset state
    repeat (2) @(negedge clock_100Khz);
    check("rst grant", o_grant, '0);
    check("rst done", o_done, '0);
    check("rst err", o_err, '0);
    check("rst en", o_en_I2C, 1'b0);
    check("rst data_read", o_data_read, 8'h00);
    check("rst addr_ic", o_addr_ic, 7'h00);
    check("rst addr_reg", o_addr_reg, 8'h00);
    check("rst data_wr", o_data_wr, 8'h00);
    check("rst wr_en", o_wr_en, 1'b0);
    i_reset = 1'b0;

    // Single write by requester 1, then a read by requester 2
    set_fields(0, 7'h11, 8'h01, 8'hF0, 1'b0);
    set_fields(1, 7'h3C, 8'h10, 8'hA5, 1'b1);
    set_fields(2, 7'h2A, 8'h22, 8'h77, 1'b0);
    set_fields(3, 7'h33, 8'h03, 8'h0F, 1'b0);
    vt[0] = '{4'b0010, 1'b0, 1'b0, 8'h00, 4'b0010, 4'b0000, 1'b1, 8'h00, 1'b1, 7'h3C, 8'h10, 8'hA5, 1'b1};
    vt[1] = '{4'b0010, 1'b0, 1'b0, 8'h00, 4'b0010, 4'b0000, 1'b1, 8'h00, 1'b1, 7'h3C, 8'h10, 8'hA5, 1'b1};
    vt[2] = '{4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0010, 1'b0, 8'h00, 1'b0, 7'h00, 8'h00, 8'h00, 1'b0};
    vt[3] = '{4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 7'h00, 8'h00, 8'h00, 1'b0};
    vt[4] = '{4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 7'h00, 8'h00, 8'h00, 1'b0};
    vt[5] = '{4'b0100, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b0000, 1'b1, 8'h00, 1'b1, 7'h2A, 8'h22, 8'h77, 1'b0};
    vt[6] = '{4'b0100, 1'b1, 1'b0, 8'h00, 4'b0100, 4'b0000, 1'b1, 8'h00, 1'b1, 7'h2A, 8'h22, 8'h77, 1'b0};
    vt[7] = '{4'b0100, 1'b0, 1'b1, 8'h5A, 4'b0000, 4'b0100, 1'b0, 8'h5A, 1'b0, 7'h00, 8'h00, 8'h00, 1'b0};
    vt[8] = '{4'b0000, 1'b0, 1'b0, 8'hFF, 4'b0000, 4'b0000, 1'b0, 8'h5A, 1'b0, 7'h00, 8'h00, 8'h00, 1'b0};
    vt[9] = '{4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0, 8'h5A, 1'b0, 7'h00, 8'h00, 8'h00, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_req       = vt[i].req;
      i_flag_w    = vt[i].fw;
      i_flag_r    = vt[i].fr;
      i_data_read = vt[i].rd;
      @(negedge clock_100Khz);
      check($sformatf("vec%0d grant", i), o_grant, vt[i].grant);
      check($sformatf("vec%0d done", i), o_done, vt[i].done);
      check($sformatf("vec%0d err", i), o_err, '0);
      check($sformatf("vec%0d en", i), o_en_I2C, vt[i].en);
      check($sformatf("vec%0d data_read", i), o_data_read, vt[i].dout);
      if (vt[i].chk_cmd) begin
        check($sformatf("vec%0d addr_ic", i), o_addr_ic, vt[i].ic);
        check($sformatf("vec%0d addr_reg", i), o_addr_reg, vt[i].rg);
        check($sformatf("vec%0d data_wr", i), o_data_wr, vt[i].dw);
        check($sformatf("vec%0d wr_en", i), o_wr_en, vt[i].wr);
      end
    end

    // Round-robin with all four requesting, then 1001 with the pointer at 1
    do_reset();
    i_wr_en     = 4'b1110;
    i_data_read = 8'hC3;
    i_req       = 4'b1111;
    serve(0, "rr0");
    serve(1, "rr1");
    serve(2, "rr2");
    serve(3, "rr3");
    serve(0, "rr4");
    i_req = 4'b1001;
    serve(3, "rr5");
    serve(0, "rr6");
    i_req = '0;
    check("rr read data", o_data_read, 8'hC3);
    i_wr_en = 4'b1111;

`ifdef I2C_ARB_TIMEOUT_EN
    // Master never flags: abort after TMO BUSY cycles
    i_req = 4'b0001;
    wait_grant("tmo", 0);
    bad = 0;
    for (int c = 2; c <= TMO; c++) begin
      @(negedge clock_100Khz);
      if (o_done != '0 || o_en_I2C !== 1'b1) bad++;
    end
    check("tmo early end", bad, 0);
    @(negedge clock_100Khz);
    check("tmo done", o_done, 4'b0001);
    check("tmo err", o_err, 4'b0001);
    check("tmo data_read", o_data_read, 8'h00);
    check("tmo en", o_en_I2C, 1'b0);
    i_req = '0;
    @(negedge clock_100Khz);

    // Flag arriving in the last BUSY cycle beats the timeout
    i_req = 4'b0001;
    wait_grant("tmo race", 0);
    for (int c = 2; c <= TMO; c++) begin
      @(negedge clock_100Khz);
      if (c == TMO) i_flag_w = 1'b1;
    end
    @(negedge clock_100Khz);
    check("tmo race done", o_done, 4'b0001);
    check("tmo race err", o_err, '0);
    i_flag_w = 1'b0;
    i_req    = '0;
    @(negedge clock_100Khz);
`endif

    // Flag held after done keeps the next grant back
    i_req = 4'b0001;
    wait_grant("hold", 0);
    i_flag_w = 1'b1;
    @(negedge clock_100Khz);
    check("hold done", o_done, 4'b0001);
    bad = 0;
    repeat (5) begin
      @(negedge clock_100Khz);
      if (o_grant != '0) bad++;
    end
    check("hold no grant while flag", bad, 0);
    i_flag_w = 1'b0;
    @(negedge clock_100Khz);
    check("hold no grant on release exit", o_grant, '0);
    @(negedge clock_100Khz);
    check("hold grant after release", o_grant, 4'b0001);

    // Async reset in the middle of BUSY
    check("mid rst en before", o_en_I2C, 1'b1);
    #2 i_reset = 1'b1;
    #1;
    check("mid rst en", o_en_I2C, 1'b0);
    check("mid rst grant", o_grant, '0);
    check("mid rst done", o_done, '0);
    check("mid rst addr_ic", o_addr_ic, 7'h00);
    i_req = 4'b1000;
    @(negedge clock_100Khz);
    check("mid rst no done", o_done, '0);
    i_reset = 1'b0;
    @(negedge clock_100Khz);
    check("post rst grant", o_grant, 4'b1000);
    check("post rst en", o_en_I2C, 1'b1);
    i_flag_w = 1'b1;
    @(negedge clock_100Khz);
    check("post rst done", o_done, 4'b1000);
    i_flag_w = 1'b0;
    i_req    = '0;
    @(negedge clock_100Khz);

    // Randomized traffic against the round-robin reference model
    do_reset();
    ptr_m       = 0;
    owner_m     = -1;
    m_phase     = 0;
    m_cnt       = 0;
    grants_seen = 0;
    exp_done    = 1'b0;
    dout_m      = 8'h00;
    m_data      = 8'h00;
    lat_wr      = 1'b0;
    lat_ic      = '0;
    lat_rg      = '0;
    lat_dw      = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock_100Khz);
      if (exp_done) begin
        check("rnd done", o_done, N'(1) << owner_m);
        check("rnd err", o_err, '0);
        check("rnd grant cleared", o_grant, '0);
        check("rnd en cleared", o_en_I2C, 1'b0);
        if (!lat_wr) dout_m = m_data;
        check("rnd data_read", o_data_read, dout_m);
        ptr_m          = (owner_m + 1) % N;
        i_req[owner_m] = 1'b0;
        owner_m        = -1;
        exp_done       = 1'b0;
      end else if (owner_m >= 0) begin
        check("rnd grant held", o_grant, N'(1) << owner_m);
        check("rnd no early done", o_done, '0);
      end else if (o_grant != '0) begin
        exp_k = -1;
        for (int j = 0; j < N; j++)
          if (exp_k < 0 && i_req[(ptr_m + j) % N]) exp_k = (ptr_m + j) % N;
        check("rnd grant pick", o_grant, (exp_k < 0) ? 0 : (N'(1) << exp_k));
        if (exp_k < 0) exp_k = 0;
        owner_m = exp_k;
        lat_ic  = i_addr_ic[7*exp_k +: 7];
        lat_rg  = i_addr_reg[8*exp_k +: 8];
        lat_dw  = i_data_wr[8*exp_k +: 8];
        lat_wr  = i_wr_en[exp_k];
        check("rnd latch addr_ic", o_addr_ic, lat_ic);
        check("rnd latch addr_reg", o_addr_reg, lat_rg);
        check("rnd latch data_wr", o_data_wr, lat_dw);
        check("rnd latch wr_en", o_wr_en, lat_wr);
        check("rnd latch en", o_en_I2C, 1'b1);
        grants_seen++;
      end else if (o_done != '0) begin
        check("rnd spurious done", o_done, '0);
      end

      i_data_read = 8'($urandom);
      case (m_phase)
        0: if (owner_m >= 0) begin
          m_cnt   = $urandom_range(0, 4);
          m_phase = 1;
          if ($urandom_range(0, 3) == 0) begin
            if (lat_wr) i_flag_r = 1'b1;
            else        i_flag_w = 1'b1;
          end
        end
        1: if (m_cnt == 0) begin
          check("rnd frozen addr_ic", o_addr_ic, lat_ic);
          check("rnd frozen data_wr", o_data_wr, lat_dw);
          if (lat_wr) i_flag_w = 1'b1;
          else        i_flag_r = 1'b1;
          m_data   = i_data_read;
          exp_done = 1'b1;
          m_phase  = 2;
        end else m_cnt--;
        2: if (owner_m < 0) begin
          m_cnt   = $urandom_range(0, 3);
          m_phase = 3;
        end
        default: if (m_cnt == 0) begin
          i_flag_w = 1'b0;
          i_flag_r = 1'b0;
          m_phase  = 0;
        end else m_cnt--;
      endcase

      for (int k = 0; k < N; k++) begin
        if (k == owner_m) begin
          set_fields(k, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
          if ($urandom_range(0, 7) == 0) i_req[k] = 1'b0;
        end else if (!i_req[k] && $urandom_range(0, 3) == 0) begin
          set_fields(k, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
          i_req[k] = 1'b1;
        end
      end
    end
    check("rnd progress", (grants_seen >= 100) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
Name: i2c_arbiter

Overview:
Shares one i2c master engine between NUM_REQ requesters, such as a sensor poller, a config loader and a debug port. Arbitration is round-robin. The arbiter latches the winning requester's transaction fields and drives the master's command inputs. It sequences the master's enable/done-flag handshake and returns read data and a one-cycle done pulse to the owner. It sits between the requesters and the i2c master, and runs in the master's clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT_CYCLES, 2000, maximum BUSY cycles before abort; used only with I2C_ARB_TIMEOUT_EN.

Ports:
clock_100Khz  input  1  system/i2c clock; all logic on rising edge.
i_reset  input  1  asynchronous, active-high reset.
i_req  input  NUM_REQ  per-requester request; hold high until own o_done.
i_wr_en  input  NUM_REQ  per-requester op: 1 = write, 0 = read.
i_addr_ic  input  7*NUM_REQ  packed slave addresses; requester k uses bits [7k+6:7k].
i_addr_reg  input  8*NUM_REQ  packed register addresses.
i_data_wr  input  8*NUM_REQ  packed write data.
o_grant  output  NUM_REQ  one-hot owner; high from latch until done.
o_done  output  NUM_REQ  one-cycle pulse to owner at completion.
o_err  output  NUM_REQ  one-cycle pulse coincident with o_done on abort.
o_data_read  output  8  read result; valid in the o_done cycle, held until the next completion.
o_addr_ic  output  7  to master.
o_addr_reg  output  8  to master.
o_data_wr  output  8  to master.
o_wr_en  output  1  to master.
o_en_I2C  output  1  to master: 1 = run transaction.
i_flag_w  input  1  master write-done (level).
i_flag_r  input  1  master read-done (level).
i_data_read  input  8  master read data.

Behaviour:
- Reset values: all outputs are 0; state = IDLE; round-robin pointer = 0; timeout counter = 0.
- IDLE:
  - If any i_req is high, pick the first requester at or after the pointer (wrapping modulo NUM_REQ).
  - Latch that requester's op, addresses and data into the master command regs.
  - Set o_grant one-hot and o_en_I2C = 1. All of these are visible the cycle after the request is sampled.
  - Go to BUSY.
- BUSY:
  - Master command outputs stay frozen; later changes on requester inputs are ignored.
  - Completion flag is i_flag_w for a write and i_flag_r for a read; the other flag is ignored.
  - When the completion flag is high: o_en_I2C = 0; o_done[owner] pulses for 1 cycle; for a read, o_data_read = i_data_read captured that cycle, otherwise o_data_read is unchanged; o_grant clears; pointer = owner+1 (wrapping); go to RELEASE.
  - If the owner drops i_req mid-transaction, the transaction still completes and o_done still pulses.
- RELEASE:
  - Wait until i_flag_w = 0 and i_flag_r = 0, then go to IDLE.
  - No grant is issued in RELEASE. This guarantees the master has cleared its flags before the next transaction.
- Minimum spacing between grants is 3 cycles: IDLE latch, BUSY done, RELEASE exit.
- Simultaneous requests: strict rotation, so each requester is served at most once per NUM_REQ grants while the others are pending.
- Async reset mid-transaction: o_en_I2C drops immediately; no o_done is generated; the pointer returns to 0.

Optional Feature:
Macro I2C_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no completion flag: o_en_I2C = 0; o_done[owner] and o_err[owner] pulse together; o_data_read = 8'h00; pointer advances; go to RELEASE.
  - A completion flag in the same cycle as the timeout wins, so no error is reported.
- Not defined: o_err is tied to 0, there is no counter, and BUSY waits indefinitely.

Test Plan:
- Single write: req[1] with wr_en = 1, addr_ic 7'h3C, addr_reg 8'h10, data_wr 8'hA5 -> next cycle o_grant = 4'b0010, o_en_I2C = 1 and master outputs 3C/10/A5. Raise i_flag_w -> o_done[1] pulses once and o_en_I2C = 0. Drop the flag -> back to IDLE.
- Read: req[2] with wr_en = 0. The model returns i_data_read = 8'h5A with i_flag_r -> o_data_read = 8'h5A in the o_done[2] cycle. The value is still 5A after the flag clears.
- Round-robin: req = 4'b1111 held with the model auto-completing -> grant order 0, 1, 2, 3, 0. Then with req = 4'b1001 and pointer at 1 -> grant order 3, 0.
- Flag hold-off: keep i_flag_w high 5 cycles after done, with req[0] pending -> no new grant until the cycle after the flag falls.
- Reset mid-BUSY: assert i_reset while o_en_I2C = 1 -> all outputs are 0 immediately and no o_done. After release, req[3] alone is granted.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 20): the master never flags -> o_done[0] and o_err[0] pulse on the 20th BUSY cycle, o_data_read = 00, o_en_I2C = 0.
